mc_bank_dispatch: RTL and testbench
===================================

# mc_bank_dispatch

Parametrised successor to the single-channel memory-controller decoder. Accepts DiRAM requests from the system port and buffers them in an internal input FIFO. Decodes each request's bank from address bits and dispatches it in strict arrival order to one of NUM_BANKS bank controllers over a shared request bus with per-bank valid/ready handshakes. Sits between the system request interface and the bank-controller array.

## Interface
- NUM_BANKS, 32, number of bank-controller ports; power of two, ≥2
- ADDR_W, 32, system address width
- DATA_W, 256, write-data width
- FIFO_DEPTH, 8, input FIFO entries; power of two, ≥2
- BANK_LSB, 5, lowest address bit of the bank field; bank = addr[BANK_LSB +: $clog2(NUM_BANKS)]
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- sys__mc__dram_req  in  1  request strobe; one request per cycle it is high
- sys__mc__dram_rdwr  in  1  0 = read, 1 = write
- sys__mc__dram_addr  in  ADDR_W  request address
- sys__mc__dram_wr_data  in  DATA_W  write data; ignored for reads but still stored
- mc__sys__dram_busy  out  1  FIFO full; a request presented while high is dropped
- input_fifo_empty  out  1  FIFO holds no entries
- input_fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- dec__bnc__valid  out  NUM_BANKS  one-hot valid, at most one bit set
- bnc__dec__ready  in  NUM_BANKS  per-bank ready
- dec__bnc__rdwr  out  1  shared bus: rdwr of the dispatched request
- dec__bnc__addr  out  ADDR_W  shared bus: full address
- dec__bnc__wr_data  out  DATA_W  shared bus: write data
- stat__drop_cnt  out  16  dropped-request count (MC_DEC_STATS_EN only)
- stat__rd_cnt, stat__wr_cnt  out  32 each  dispatched read/write counts (MC_DEC_STATS_EN only)

## Operation
- **Push:** when req=1 and busy=0, write {rdwr, addr, wr_data} at the write pointer. When req=1 and busy=1, the request is dropped and nothing is written.
- **busy:** busy = (count == FIFO_DEPTH), decoded from the registered count. A pop in the same cycle does not clear busy for that cycle.
- **Output stage:** a single register holding one request plus a one-hot bank select. dec__bnc__valid = out_valid ? onehot(bank) : 0.
- **Handshake:** a transfer occurs when dec__bnc__valid[b] & bnc__dec__ready[b]. Ready bits of non-selected banks are ignored. Shared bus fields and valid hold stable until the transfer.
- **Pop:** when the FIFO is non-empty and the output stage is either empty or transferring this cycle, pop the head into the output stage.
- **Ordering:** strictly in order. A stalled bank blocks all later requests (head-of-line), and no reordering is done.
- **Counting:**
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **Reset:**
  - All of the following are forced to 0: pointers, count, out_valid, valid, busy, shared bus fields and statistics.
  - input_fifo_empty is forced to 1.
  - In-flight and buffered requests are discarded, with no partial transfer.

## Timing
- A request sampled at the end of cycle 0 is stored in cycle 1 and visible on dec__bnc__* in cycle 2, given an empty pipeline and a free output stage. Latency is 2 cycles.
- Throughput is one dispatch per cycle while target banks hold ready high.
- input_fifo_empty, input_fifo_count and busy update on the edge after a push or pop.
- Output fields are registered. There is no combinational path from bnc__dec__ready to dec__bnc__valid or the bus.

## Configuration
- **MC_DEC_STATS_EN defined:**
  - stat__drop_cnt increments on each dropped request and saturates at 16'hFFFF.
  - stat__rd_cnt and stat__wr_cnt increment on each completed transfer and wrap.
- **Undefined:** the stat__* ports and their counters are absent. Everything else is identical.

## Structure
- Package mc_dec_pkg holds:
  - the rdwr encodings MC_RD = 1'b0 and MC_WR = 1'b1;
  - the typedef mc_req_t (rdwr, addr, wr_data), parameterised via package parameters matching the defaults;
  - a bank-extract function.
- Sub-module mc_sync_fifo is a parameterised synchronous FIFO with push/pop/full/empty/count. It is instantiated once. The top level holds the output stage and statistics.

## Test plan
- Single write to addr 0x0000_0060 with bank field 3 and all banks ready: dec__bnc__valid = 32'h8 in cycle 2, with addr and wr_data matching. The transfer completes in that cycle and input_fifo_empty returns to 1.
- Hold bank 3 ready low and issue 9 requests to bank 3: 1 request sits in the output stage and 8 are buffered. busy=1 and input_fifo_count=8. A 10th request is dropped, and with MC_DEC_STATS_EN stat__drop_cnt=1.
- Alternate banks 0 and 1 with both ready for 16 cycles: one transfer per cycle, in order. Each bus payload equals its pushed payload.
- Bank 5 stalled at the head with a bank 6 request behind it: bank 6 sees no valid until ready[5] is asserted (head-of-line). Bank 6 then follows 1 cycle later.
- Full FIFO with simultaneous push and pop: the push is dropped because busy was 1, and count goes from 8 to 7.
- Assert reset low mid-stream with 4 entries buffered: within the same cycle, valid=0, count=0, busy=0 and empty=1. After reset is released, the first new request is dispatched with 2-cycle latency.

Source files
------------

// File: rtl/mc_dec_pkg.sv
// +------------------------------------------------------------------+
// | mc_dec_pkg: shared encodings, request type and bank extraction    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package mc_dec_pkg;

    localparam logic MC_RD = 1'b0;
    localparam logic MC_WR = 1'b1;

    localparam int MC_ADDR_W = 32;
    localparam int MC_DATA_W = 256;

    typedef struct packed {
        logic                 rdwr;
        logic [MC_ADDR_W-1:0] addr;
        logic [MC_DATA_W-1:0] wr_data;
    } mc_req_t;

    // Width-agnostic so any ADDR_W up to 64 bits can share it.
    function automatic int mc_bank_idx(input logic [63:0] addr, input int lsb, input int bank_w);
        logic [63:0] mask;
        mask = (64'd1 << bank_w) - 64'd1;
        return int'(32'((addr >> lsb) & mask));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_sync_fifo.sv
// +------------------------------------------------------------------+
// | mc_sync_fifo: synchronous FIFO with push/pop/full/empty/count     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module mc_sync_fifo
    import mc_dec_pkg::*;
#(
    parameter int WIDTH = 289,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (count_q == c_cnt_w'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign rdata     = mem_q[rd_ptr_q];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        unique case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + c_cnt_w'(1);
            2'b01:   count_d = count_q - c_cnt_w'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

`default_nettype wire

// File: rtl/mc_bank_dispatch.sv
// +------------------------------------------------------------------+
// | mc_bank_dispatch: buffers DRAM requests, dispatches in order to   |
// | one-hot bank ports. Optional statistics: MC_DEC_STATS_EN          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module mc_bank_dispatch
    import mc_dec_pkg::*;
#(
    parameter int NUM_BANKS  = 32,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 256,
    parameter int FIFO_DEPTH = 8,
    parameter int BANK_LSB   = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sys__mc__dram_req,
    input  logic                          sys__mc__dram_rdwr,
    input  logic [ADDR_W-1:0]             sys__mc__dram_addr,
    input  logic [DATA_W-1:0]             sys__mc__dram_wr_data,
    output logic                          mc__sys__dram_busy,
    output logic                          input_fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   input_fifo_count,
    output logic [NUM_BANKS-1:0]          dec__bnc__valid,
    output logic                          dec__bnc__rdwr,
    output logic [ADDR_W-1:0]             dec__bnc__addr,
    output logic [DATA_W-1:0]             dec__bnc__wr_data,
    input  logic [NUM_BANKS-1:0]          bnc__dec__ready
`ifdef MC_DEC_STATS_EN
    ,
    output logic [15:0]                   stat__drop_cnt,
    output logic [31:0]                   stat__rd_cnt,
    output logic [31:0]                   stat__wr_cnt
`endif
);

    localparam int c_bank_w = $clog2(NUM_BANKS);
    localparam int c_req_w  = 1 + ADDR_W + DATA_W;
    localparam logic [NUM_BANKS-1:0] c_sel_lsb = {{(NUM_BANKS-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic              rdwr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wr_data;
    } disp_req_t;

    disp_req_t            w_push_req, w_head_req;
    logic                 w_push, w_pop, w_full, w_empty, w_xfer;
    logic [NUM_BANKS-1:0] w_head_sel;

    logic                 out_valid_q, out_valid_d;
    logic [NUM_BANKS-1:0] sel_q, sel_d;
    disp_req_t            out_req_q, out_req_d;

    assign w_push_req = {sys__mc__dram_rdwr, sys__mc__dram_addr, sys__mc__dram_wr_data};
    assign w_push     = sys__mc__dram_req && !w_full;
    // sel_q is all-zero whenever the output stage is empty.
    assign w_xfer     = |(sel_q & bnc__dec__ready);
    assign w_pop      = !w_empty && (!out_valid_q || w_xfer);
    assign w_head_sel = c_sel_lsb << mc_bank_idx(64'(w_head_req.addr), BANK_LSB, c_bank_w);

    mc_sync_fifo #(
        .WIDTH (c_req_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_push_req),
        .rdata (w_head_req),
        .full  (w_full),
        .empty (w_empty),
        .count (input_fifo_count)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        sel_d       = sel_q;
        out_req_d   = out_req_q;
        if (w_pop) begin
            out_valid_d = 1'b1;
            sel_d       = w_head_sel;
            out_req_d   = w_head_req;
        end else if (w_xfer) begin
            out_valid_d = 1'b0;
            sel_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            sel_q       <= '0;
            out_req_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            sel_q       <= sel_d;
            out_req_q   <= out_req_d;
        end
    end

    assign mc__sys__dram_busy = w_full;
    assign input_fifo_empty   = w_empty;
    assign dec__bnc__valid    = sel_q;
    assign dec__bnc__rdwr     = out_req_q.rdwr;
    assign dec__bnc__addr     = out_req_q.addr;
    assign dec__bnc__wr_data  = out_req_q.wr_data;

`ifdef MC_DEC_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        if (sys__mc__dram_req && w_full && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;
        if (w_xfer && (out_req_q.rdwr == MC_WR)) wr_cnt_d = wr_cnt_q + 32'd1;
        if (w_xfer && (out_req_q.rdwr == MC_RD)) rd_cnt_d = rd_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign stat__drop_cnt = drop_cnt_q;
    assign stat__rd_cnt   = rd_cnt_q;
    assign stat__wr_cnt   = wr_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_bank_dispatch.sv
// +------------------------------------------------------------------+
// | tb_mc_bank_dispatch: directed + randomized bench with queue model |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mc_bank_dispatch;

    localparam int NB    = 32;
    localparam int AW    = 32;
    localparam int DW    = 256;
    localparam int DEPTH = 8;
    localparam int LSB   = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req = 1'b0;
    logic          rdwr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [NB-1:0] ready = '0;
    logic          busy, fempty;
    logic [3:0]    fcount;
    logic [NB-1:0] valid;
    logic          b_rdwr;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
`ifdef MC_DEC_STATS_EN
    logic [15:0]   drop_cnt;
    logic [31:0]   rd_cnt, wr_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mc_bank_dispatch #(
        .NUM_BANKS (NB), .ADDR_W (AW), .DATA_W (DW), .FIFO_DEPTH (DEPTH), .BANK_LSB (LSB)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .sys__mc__dram_req     (req),
        .sys__mc__dram_rdwr    (rdwr),
        .sys__mc__dram_addr    (addr),
        .sys__mc__dram_wr_data (wdata),
        .mc__sys__dram_busy    (busy),
        .input_fifo_empty      (fempty),
        .input_fifo_count      (fcount),
        .dec__bnc__valid       (valid),
        .dec__bnc__rdwr        (b_rdwr),
        .dec__bnc__addr        (b_addr),
        .dec__bnc__wr_data     (b_data),
        .bnc__dec__ready       (ready)
`ifdef MC_DEC_STATS_EN
        ,
        .stat__drop_cnt        (drop_cnt),
        .stat__rd_cnt          (rd_cnt),
        .stat__wr_cnt          (wr_cnt)
`endif
    );

    // Reference model: the accepted-request queue plus the one slot facing the banks.
    typedef struct {
        logic          rdwr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_s;

    req_s m_fifo[$];
    req_s m_out;
    bit   m_out_v;
    int   m_drops, m_rd, m_wr;

    function automatic int bank_of(input logic [AW-1:0] a);
        return int'((a >> LSB) % NB);
    endfunction

    function automatic logic [NB-1:0] onehot_of(input logic [AW-1:0] a);
        logic [NB-1:0] v;
        v = '0;
        v[bank_of(a)] = 1'b1;
        return v;
    endfunction

    function automatic logic [AW-1:0] addr_for_bank(input int b);
        logic [AW-1:0] r;
        r = $urandom;
        r = (r & ~(AW'(NB - 1) << LSB)) | (AW'(b) << LSB);
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_out_v = 1'b0;
        m_drops = 0;
        m_rd    = 0;
        m_wr    = 0;
    endtask

    task automatic drive(input logic r, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req   = r;
        rdwr  = rw;
        addr  = a;
        wdata = d;
    endtask

    // One clock: model decides from pre-edge state, then DUT outputs are settled at edge+1.
    task automatic tick();
        bit   xfer, push, pop;
        req_s in_r;
        in_r = '{rdwr, addr, wdata};
        xfer = m_out_v && ready[bank_of(m_out.addr)];
        push = req && (m_fifo.size() < DEPTH);
        pop  = (m_fifo.size() != 0) && (!m_out_v || xfer);
        if (req && !push && m_drops < 65535) m_drops++;
        @(posedge clk);
        #1;
        if (xfer) begin
            m_out_v = 1'b0;
            if (m_out.rdwr) m_wr++; else m_rd++;
        end
        if (pop) begin
            m_out   = m_fifo.pop_front();
            m_out_v = 1'b1;
        end
        if (push) m_fifo.push_back(in_r);
    endtask

    task automatic apply_reset();
        drive(1'b0, 1'b0, '0, '0);
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        n_checks++;
        if (valid !== '0 || b_rdwr !== 1'b0 || b_addr !== '0 || b_data !== '0) begin
            n_errors++;
            $display("FAIL reset_bus: valid=%h rdwr=%b addr=%h want all zero", valid, b_rdwr, b_addr);
        end
        n_checks++;
        if (fcount !== 4'd0 || busy !== 1'b0 || fempty !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_fifo: count=%0d busy=%b empty=%b want 0/0/1", fcount, busy, fempty);
        end
`ifdef MC_DEC_STATS_EN
        n_checks++;
        if (drop_cnt !== 16'd0 || rd_cnt !== 32'd0 || wr_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_stats: drop=%0d rd=%0d wr=%0d want 0", drop_cnt, rd_cnt, wr_cnt);
        end
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_single_write();
        logic [DW-1:0] d;
        d     = rand_data();
        ready = '1;
        drive(1'b1, 1'b1, 32'h0000_0060, d);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        n_checks++;
        if (fcount !== 4'd1 || valid !== '0) begin
            n_errors++;
            $display("FAIL single_cycle1: count=%0d valid=%h want 1/0", fcount, valid);
        end
        tick();
        n_checks++;
        if (valid !== 32'h8 || b_addr !== 32'h60 || b_data !== d || b_rdwr !== 1'b1) begin
            n_errors++;
            $display("FAIL single_cycle2: valid=%h addr=%h rdwr=%b want 8/60/1 (data match=%b)",
                     valid, b_addr, b_rdwr, b_data === d);
        end
        n_checks++;
        if (fempty !== 1'b1) begin
            n_errors++;
            $display("FAIL single_empty: empty=%b want 1", fempty);
        end
        tick();
        n_checks++;
        if (valid !== '0) begin
            n_errors++;
            $display("FAIL single_done: valid=%h want 0", valid);
        end
    endtask

    task automatic test_fill_drop();
        req_s sent[9];
        apply_reset();
        ready = ~32'h8;
        for (int i = 0; i < 9; i++) begin
            sent[i] = '{1'($urandom), addr_for_bank(3), rand_data()};
            drive(1'b1, sent[i].rdwr, sent[i].addr, sent[i].data);
            tick();
        end
        drive(1'b0, 1'b0, '0, '0);
        n_checks++;
        if (fcount !== 4'd8 || busy !== 1'b1 || valid !== 32'h8 || b_addr !== sent[0].addr) begin
            n_errors++;
            $display("FAIL fill_full: count=%0d busy=%b valid=%h addr=%h want 8/1/8/%h",
                     fcount, busy, valid, b_addr, sent[0].addr);
        end
        drive(1'b1, 1'b0, addr_for_bank(3), rand_data());
        tick();
        drive(1'b0, 1'b0, '0, '0);
        n_checks++;
        if (fcount !== 4'd8 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_drop_count: count=%0d busy=%b want 8/1", fcount, busy);
        end
`ifdef MC_DEC_STATS_EN
        n_checks++;
        if (drop_cnt !== 16'd1) begin
            n_errors++;
            $display("FAIL fill_drop_stat: drop=%0d want 1", drop_cnt);
        end
`endif
        ready = '1;
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (valid !== 32'h8 || b_addr !== sent[k].addr || b_data !== sent[k].data || b_rdwr !== sent[k].rdwr) begin
                n_errors++;
                $display("FAIL fill_drain[%0d]: valid=%h addr=%h want 8/%h", k, valid, b_addr, sent[k].addr);
            end
            tick();
        end
        n_checks++;
        if (valid !== '0 || fempty !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_drained: valid=%h empty=%b want 0/1", valid, fempty);
        end
    endtask

    task automatic test_alternate();
        req_s sent[16];
        apply_reset();
        ready = 32'h3;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                sent[i] = '{1'($urandom), addr_for_bank(i % 2), rand_data()};
                drive(1'b1, sent[i].rdwr, sent[i].addr, sent[i].data);
            end else begin
                drive(1'b0, 1'b0, '0, '0);
            end
            tick();
            if (i >= 1) begin
                n_checks++;
                if (valid !== (((i - 1) % 2 == 1) ? 32'h2 : 32'h1) || b_addr !== sent[i-1].addr ||
                    b_data !== sent[i-1].data || b_rdwr !== sent[i-1].rdwr) begin
                    n_errors++;
                    $display("FAIL alt[%0d]: valid=%h addr=%h want bank %0d addr %h",
                             i - 1, valid, b_addr, (i - 1) % 2, sent[i-1].addr);
                end
            end
        end
        tick();
    endtask

    task automatic test_hol();
        logic [AW-1:0] a5, a6;
        apply_reset();
        ready = ~32'h20;
        a5 = addr_for_bank(5);
        a6 = addr_for_bank(6);
        drive(1'b1, 1'b0, a5, rand_data());
        tick();
        drive(1'b1, 1'b1, a6, rand_data());
        tick();
        drive(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (valid !== 32'h20 || b_addr !== a5) begin
                n_errors++;
                $display("FAIL hol_stall[%0d]: valid=%h addr=%h want 20/%h", i, valid, b_addr, a5);
            end
        end
        ready = '1;
        tick();
        n_checks++;
        if (valid !== 32'h40 || b_addr !== a6 || b_rdwr !== 1'b1) begin
            n_errors++;
            $display("FAIL hol_follow: valid=%h addr=%h want 40/%h", valid, b_addr, a6);
        end
        tick();
        n_checks++;
        if (valid !== '0) begin
            n_errors++;
            $display("FAIL hol_done: valid=%h want 0", valid);
        end
    endtask

    task automatic test_full_push_pop();
        req_s sent[9];
        apply_reset();
        ready = ~32'h8;
        for (int i = 0; i < 9; i++) begin
            sent[i] = '{1'($urandom), addr_for_bank(3), rand_data()};
            drive(1'b1, sent[i].rdwr, sent[i].addr, sent[i].data);
            tick();
        end
        ready = '1;
        drive(1'b1, 1'b1, addr_for_bank(3), rand_data());
        tick();
        drive(1'b0, 1'b0, '0, '0);
        n_checks++;
        if (fcount !== 4'd7 || busy !== 1'b0 || valid !== 32'h8 || b_addr !== sent[1].addr) begin
            n_errors++;
            $display("FAIL fpp_count: count=%0d busy=%b valid=%h addr=%h want 7/0/8/%h",
                     fcount, busy, valid, b_addr, sent[1].addr);
        end
        for (int k = 2; k < 9; k++) begin
            tick();
            n_checks++;
            if (valid !== 32'h8 || b_addr !== sent[k].addr) begin
                n_errors++;
                $display("FAIL fpp_drain[%0d]: valid=%h addr=%h want 8/%h", k, valid, b_addr, sent[k].addr);
            end
        end
        tick();
        n_checks++;
        if (valid !== '0 || fempty !== 1'b1) begin
            n_errors++;
            $display("FAIL fpp_no_ghost: valid=%h empty=%b want 0/1", valid, fempty);
        end
    endtask

    task automatic test_reset_midstream();
        logic [AW-1:0] a7;
        apply_reset();
        ready = ~32'h8;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, addr_for_bank(3), rand_data());
            tick();
        end
        drive(1'b0, 1'b0, '0, '0);
        n_checks++;
        if (fcount !== 4'd4 || valid !== 32'h8) begin
            n_errors++;
            $display("FAIL rstmid_pre: count=%0d valid=%h want 4/8", fcount, valid);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (valid !== '0 || fcount !== 4'd0 || busy !== 1'b0 || fempty !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_async: valid=%h count=%0d busy=%b empty=%b want 0/0/0/1",
                     valid, fcount, busy, fempty);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        ready = '1;
        a7 = addr_for_bank(7);
        drive(1'b1, 1'b1, a7, rand_data());
        tick();
        drive(1'b0, 1'b0, '0, '0);
        n_checks++;
        if (valid !== '0) begin
            n_errors++;
            $display("FAIL rstmid_lat1: valid=%h want 0", valid);
        end
        tick();
        n_checks++;
        if (valid !== 32'h80 || b_addr !== a7) begin
            n_errors++;
            $display("FAIL rstmid_lat2: valid=%h addr=%h want 80/%h", valid, b_addr, a7);
        end
        tick();
    endtask

    task automatic test_random();
        logic [NB-1:0] exp_valid;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            ready = $urandom | $urandom;
            drive(1'(($urandom % 4) != 0), 1'($urandom), addr_for_bank(int'($urandom % NB)), rand_data());
            tick();
            exp_valid = m_out_v ? onehot_of(m_out.addr) : '0;
            n_checks++;
            if (valid !== exp_valid || fcount !== 4'(m_fifo.size()) ||
                busy !== (m_fifo.size() == DEPTH) || fempty !== (m_fifo.size() == 0)) begin
                n_errors++;
                $display("FAIL rand_ctl[%0d]: valid=%h count=%0d busy=%b empty=%b want %h/%0d",
                         c, valid, fcount, busy, fempty, exp_valid, m_fifo.size());
            end
            if (m_out_v) begin
                n_checks++;
                if (b_addr !== m_out.addr || b_data !== m_out.data || b_rdwr !== m_out.rdwr) begin
                    n_errors++;
                    $display("FAIL rand_bus[%0d]: addr=%h rdwr=%b want %h/%b", c, b_addr, b_rdwr,
                             m_out.addr, m_out.rdwr);
                end
            end
`ifdef MC_DEC_STATS_EN
            n_checks++;
            if (drop_cnt !== 16'(m_drops) || rd_cnt !== 32'(m_rd) || wr_cnt !== 32'(m_wr)) begin
                n_errors++;
                $display("FAIL rand_stats[%0d]: drop=%0d rd=%0d wr=%0d want %0d/%0d/%0d",
                         c, drop_cnt, rd_cnt, wr_cnt, m_drops, m_rd, m_wr);
            end
`endif
        end
        drive(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_drop();
        test_alternate();
        test_hol();
        test_full_push_pop();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
